// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI definitions for the memory bridges.
//   RESP_OKAY / RESP_SLVERR : AXI response codes driven on RRESP/BRESP.
//   membr_state_e           : 3-bit state encoding of the AXI-Lite memory
//                             bridge FSM. Reusable by any future bridge.
// -----------------------------------------------------------------------------
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    MEMBR_IDLE       = 3'd0,
    MEMBR_WR_COLLECT = 3'd1,
    MEMBR_RD_MEM     = 3'd2,
    MEMBR_WR_MEM     = 3'd3,
    MEMBR_RD_RESP    = 3'd4,
    MEMBR_WR_RESP    = 3'd5
  } membr_state_e;

endpackage

// File: rtl/axi_lite_mem_bridge.sv
// -----------------------------------------------------------------------------
// axi_lite_mem_bridge
// AXI4-Lite slave to word-addressed request/ready memory bus. One transaction
// is in flight at a time; reads win only when the bridge is idle.
//
// Parameters
//   BASE_ADDR : byte address subtracted from AXI addresses (wrapping).
//   DEPTH     : memory size in 32-bit words (power of two, >= 2).
//   AW        : memory word-address width, derived from DEPTH.
// Ports
//   clk_i, rst_i                  : clock, synchronous active-high reset.
//   s_ar*, s_r*                   : AXI read address / read data channels.
//   s_aw*, s_w*, s_b*             : AXI write address / data / response.
//   mem_req_o .. mem_wstrb_o      : memory request, held until mem_ready_i.
//   mem_rdata_i, mem_ready_i      : memory completion and read data.
//
// Handshake rule: every channel transfers on a rising edge where valid and
// ready are both high; a raised valid (ours) is held, with stable payload,
// until that edge.
//
// Configuration macro: AXI_MEM_RANGE_CHECK_EN. When defined, accesses whose
// offset is >= 4*DEPTH skip the memory and respond SLVERR (read data 0).
// When undefined the offset is truncated to AW bits and always OKAY.
//
// The FSM state is held in state_q (membr_state_e) for checker binding.
// -----------------------------------------------------------------------------
module axi_lite_mem_bridge
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          AW        = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          s_arvalid_i,
  output logic          s_arready_o,
  input  logic [31:0]   s_araddr_i,
  output logic          s_rvalid_o,
  input  logic          s_rready_i,
  output logic [31:0]   s_rdata_o,
  output logic [1:0]    s_rresp_o,
  input  logic          s_awvalid_i,
  output logic          s_awready_o,
  input  logic [31:0]   s_awaddr_i,
  input  logic          s_wvalid_i,
  output logic          s_wready_o,
  input  logic [31:0]   s_wdata_i,
  input  logic [3:0]    s_wstrb_i,
  output logic          s_bvalid_o,
  input  logic          s_bready_i,
  output logic [1:0]    s_bresp_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic [3:0]    mem_wstrb_o,
  input  logic [31:0]   mem_rdata_i,
  input  logic          mem_ready_i
);

  membr_state_e state_q, state_d;

  logic [31:0] ar_q, aw_q, w_data_q, rdata_q;
  logic [3:0]  w_strb_q;
  logic        aw_have, w_have;
  logic [1:0]  resp_q;

  logic ar_hs, aw_hs, w_hs;
  logic wr_go;    // both write halves present (captured or arriving now)
  logic rd_skip;  // read bypasses memory (out of range)
  logic wr_skip;  // write bypasses memory (out of range)

  logic [31:0] ar_off, aw_off;

  assign ar_off = ar_q - BASE_ADDR;
  assign aw_off = aw_q - BASE_ADDR;

  // Offset bits that never reach the memory address.
  logic unused_off_bits;
  assign unused_off_bits = ^{ar_off[31:AW+2], ar_off[1:0],
                             aw_off[31:AW+2], aw_off[1:0]};

  // Ready outputs are forced low while reset is asserted.
  assign s_arready_o = !rst_i && (state_q == MEMBR_IDLE);
  assign s_awready_o = !rst_i && ((state_q == MEMBR_IDLE && !s_arvalid_i) ||
                                  (state_q == MEMBR_WR_COLLECT && !aw_have));
  assign s_wready_o  = !rst_i && ((state_q == MEMBR_IDLE && !s_arvalid_i) ||
                                  (state_q == MEMBR_WR_COLLECT && !w_have));

  assign ar_hs = s_arvalid_i && s_arready_o;
  assign aw_hs = s_awvalid_i && s_awready_o;
  assign w_hs  = s_wvalid_i  && s_wready_o;

  // Going on the arriving handshake (not the registered flag) keeps the
  // memory phase one cycle after the later of the AW/W handshakes.
  assign wr_go = (state_q == MEMBR_IDLE || state_q == MEMBR_WR_COLLECT) &&
                 (aw_have || aw_hs) && (w_have || w_hs);

`ifdef AXI_MEM_RANGE_CHECK_EN
  logic [31:0] rd_off_new, wr_off_new;
  assign rd_off_new = s_araddr_i - BASE_ADDR;
  assign wr_off_new = (aw_hs ? s_awaddr_i : aw_q) - BASE_ADDR;
  assign rd_skip    = ar_hs && (rd_off_new >= (32'(DEPTH) << 2));
  assign wr_skip    = wr_go && (wr_off_new >= (32'(DEPTH) << 2));
`else
  assign rd_skip = 1'b0;
  assign wr_skip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEMBR_IDLE: begin
        if (ar_hs)               state_d = rd_skip ? MEMBR_RD_RESP : MEMBR_RD_MEM;
        else if (wr_go)          state_d = wr_skip ? MEMBR_WR_RESP : MEMBR_WR_MEM;
        else if (aw_hs || w_hs)  state_d = MEMBR_WR_COLLECT;
      end
      MEMBR_WR_COLLECT: if (wr_go) state_d = wr_skip ? MEMBR_WR_RESP : MEMBR_WR_MEM;
      MEMBR_RD_MEM:     if (mem_ready_i) state_d = MEMBR_RD_RESP;
      MEMBR_WR_MEM:     if (mem_ready_i) state_d = MEMBR_WR_RESP;
      MEMBR_RD_RESP:    if (s_rready_i)  state_d = MEMBR_IDLE;
      MEMBR_WR_RESP:    if (s_bready_i)  state_d = MEMBR_IDLE;
      default:          state_d = MEMBR_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= MEMBR_IDLE;
      ar_q     <= '0;
      aw_q     <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      aw_have  <= 1'b0;
      w_have   <= 1'b0;
      rdata_q  <= '0;
      resp_q   <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      if (ar_hs) ar_q <= s_araddr_i;
      if (aw_hs) begin
        aw_q    <= s_awaddr_i;
        aw_have <= 1'b1;
      end
      if (w_hs) begin
        w_data_q <= s_wdata_i;
        w_strb_q <= s_wstrb_i;
        w_have   <= 1'b1;
      end
      if (state_q == MEMBR_RD_MEM && mem_ready_i) begin
        rdata_q <= mem_rdata_i;
        resp_q  <= RESP_OKAY;
      end
      if (state_q == MEMBR_WR_MEM && mem_ready_i) resp_q <= RESP_OKAY;
      if (rd_skip) begin
        rdata_q <= '0;
        resp_q  <= RESP_SLVERR;
      end
      if (wr_skip) resp_q <= RESP_SLVERR;
      if (state_q == MEMBR_WR_RESP && s_bready_i) begin
        aw_have <= 1'b0;
        w_have  <= 1'b0;
      end
    end
  end

  assign mem_req_o   = !rst_i && (state_q == MEMBR_RD_MEM || state_q == MEMBR_WR_MEM);
  assign mem_we_o    = !rst_i && (state_q == MEMBR_WR_MEM);
  assign mem_addr_o  = !mem_req_o ? '0 :
                       (state_q == MEMBR_RD_MEM) ? ar_off[AW+1:2] : aw_off[AW+1:2];
  assign mem_wdata_o = mem_we_o ? w_data_q : '0;
  assign mem_wstrb_o = mem_we_o ? w_strb_q : '0;

  assign s_rvalid_o  = !rst_i && (state_q == MEMBR_RD_RESP);
  assign s_rdata_o   = s_rvalid_o ? rdata_q : '0;
  assign s_rresp_o   = s_rvalid_o ? resp_q  : '0;
  assign s_bvalid_o  = !rst_i && (state_q == MEMBR_WR_RESP);
  assign s_bresp_o   = s_bvalid_o ? resp_q  : '0;

endmodule

// File: tb/tb_axi_lite_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_mem_bridge
// Self-checking bench for axi_lite_mem_bridge (BASE_ADDR 32'h1000_0000,
// DEPTH 1024). A reference memory predicts read data; expected memory
// accesses, R beats and B responses are queued when stimulus is driven and
// compared when the bridge produces them. Honours AXI_MEM_RANGE_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_axi_lite_mem_bridge;
  import axi_pkg::*;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam int          DEPTH  = 1024;
  localparam int          AW     = 10;
  localparam int          ACC_W  = 1 + AW + 32 + 4;
  localparam int          R_W    = 34;
  localparam int          BUDGET = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic          s_arvalid_i = 1'b0, s_arready_o;
  logic [31:0]   s_araddr_i = '0;
  logic          s_rvalid_o, s_rready_i = 1'b0;
  logic [31:0]   s_rdata_o;
  logic [1:0]    s_rresp_o;
  logic          s_awvalid_i = 1'b0, s_awready_o;
  logic [31:0]   s_awaddr_i = '0;
  logic          s_wvalid_i = 1'b0, s_wready_o;
  logic [31:0]   s_wdata_i = '0;
  logic [3:0]    s_wstrb_i = '0;
  logic          s_bvalid_o, s_bready_i = 1'b0;
  logic [1:0]    s_bresp_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [3:0]    mem_wstrb_o;
  logic [31:0]   mem_rdata_i = '0;
  logic          mem_ready_i = 1'b0;

  axi_lite_mem_bridge #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o), .s_araddr_i(s_araddr_i),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i), .s_rdata_o(s_rdata_o),
    .s_rresp_o(s_rresp_o),
    .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o), .s_awaddr_i(s_awaddr_i),
    .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o), .s_wdata_i(s_wdata_i),
    .s_wstrb_i(s_wstrb_i),
    .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i), .s_bresp_o(s_bresp_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int mem_stall = 0;

  logic [R_W-1:0]   exp_q[$];      // {rresp, rdata}
  logic [1:0]       exp_b_q[$];    // bresp
  logic [ACC_W-1:0] exp_acc_q[$];  // {we, addr, wdata, wstrb}

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] dut_mem [DEPTH];

  function automatic logic [AW-1:0] word_of(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return off[AW+1:2];
  endfunction

  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
`ifdef AXI_MEM_RANGE_CHECK_EN
    return off < 32'(4 * DEPTH);
`else
    return (off != 32'hFFFF_FFFF) || 1'b1;
`endif
  endfunction

  // ---------------- memory responder ----------------
  initial begin : mem_model
    int stall_cnt;
    logic busy;
    logic [ACC_W-1:0] first, got, exp;
    busy = 1'b0;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      mem_ready_i = 1'b0;
      mem_rdata_i = '0;
      got = {mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o};
      if (mem_req_o === 1'b1) begin
        checks++;
        if (!busy) begin
          busy = 1'b1;
          stall_cnt = 0;
          first = got;
          if (exp_acc_q.size() == 0) begin
            errors++;
            $display("FAIL mem_access_unexpected: got %h, no access expected", got);
          end else begin
            exp = exp_acc_q.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL mem_access: got %h required %h", got, exp);
            end
          end
        end else if (got !== first) begin
          errors++;
          $display("FAIL mem_hold: got %h required %h", got, first);
        end
        if (stall_cnt >= mem_stall) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = dut_mem[mem_addr_o];
          if (mem_we_o)
            for (int b = 0; b < 4; b++)
              if (mem_wstrb_o[b]) dut_mem[mem_addr_o][8*b +: 8] = mem_wdata_o[8*b +: 8];
          acc_cnt++;
          busy = 1'b0;
        end else begin
          stall_cnt++;
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All start aligned to a negedge and return #1 after the handshake edge.
  task automatic send_ar(input logic [31:0] a, input int dly);
    int n;
    n = 0;
    repeat (dly) @(negedge clk);
    s_arvalid_i = 1'b1; s_araddr_i = a; #1;
    while (s_arready_o !== 1'b1 && n < BUDGET) begin @(negedge clk); #1; n++; end
    if (n >= BUDGET) begin
      checks++; errors++;
      $display("FAIL ar_timeout: arready=%b after %0d cycles, required 1", s_arready_o, n);
    end else @(posedge clk);
    #1; s_arvalid_i = 1'b0; s_araddr_i = '0;
  endtask

  task automatic send_aw(input logic [31:0] a, input int dly);
    int n;
    n = 0;
    repeat (dly) @(negedge clk);
    s_awvalid_i = 1'b1; s_awaddr_i = a; #1;
    while (s_awready_o !== 1'b1 && n < BUDGET) begin @(negedge clk); #1; n++; end
    if (n >= BUDGET) begin
      checks++; errors++;
      $display("FAIL aw_timeout: awready=%b after %0d cycles, required 1", s_awready_o, n);
    end else @(posedge clk);
    #1; s_awvalid_i = 1'b0; s_awaddr_i = '0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n;
    n = 0;
    repeat (dly) @(negedge clk);
    s_wvalid_i = 1'b1; s_wdata_i = d; s_wstrb_i = s; #1;
    while (s_wready_o !== 1'b1 && n < BUDGET) begin @(negedge clk); #1; n++; end
    if (n >= BUDGET) begin
      checks++; errors++;
      $display("FAIL w_timeout: wready=%b after %0d cycles, required 1", s_wready_o, n);
    end else @(posedge clk);
    #1; s_wvalid_i = 1'b0; s_wdata_i = '0; s_wstrb_i = '0;
  endtask

  task automatic collect_r(input int hold);
    int n;
    logic [R_W-1:0] exp;
    n = 0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL r_queue: R beat awaited with empty expectation queue");
      return;
    end
    exp = exp_q.pop_front();
    while (s_rvalid_o !== 1'b1 && n < BUDGET) begin @(negedge clk); #1; n++; end
    if (n >= BUDGET) begin
      errors++;
      $display("FAIL r_timeout: rvalid=%b after %0d cycles, required 1", s_rvalid_o, n);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({s_rvalid_o, s_rresp_o, s_rdata_o} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL r_hold: got v=%b %h required v=1 %h", s_rvalid_o, {s_rresp_o, s_rdata_o}, exp);
      end
    end
    if ({s_rresp_o, s_rdata_o} !== exp) begin
      errors++;
      $display("FAIL r_data: got resp=%b data=%h required resp=%b data=%h",
               s_rresp_o, s_rdata_o, exp[33:32], exp[31:0]);
    end
    s_rready_i = 1'b1;
    @(posedge clk); #1;
    s_rready_i = 1'b0;
  endtask

  task automatic collect_b(input int hold);
    int n;
    logic [1:0] exp;
    n = 0;
    checks++;
    if (exp_b_q.size() == 0) begin
      errors++;
      $display("FAIL b_queue: B awaited with empty expectation queue");
      return;
    end
    exp = exp_b_q.pop_front();
    while (s_bvalid_o !== 1'b1 && n < BUDGET) begin @(negedge clk); #1; n++; end
    if (n >= BUDGET) begin
      errors++;
      $display("FAIL b_timeout: bvalid=%b after %0d cycles, required 1", s_bvalid_o, n);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({s_bvalid_o, s_bresp_o} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL b_hold: got v=%b resp=%b required v=1 resp=%b", s_bvalid_o, s_bresp_o, exp);
      end
    end
    if (s_bresp_o !== exp) begin
      errors++;
      $display("FAIL b_resp: got %b required %b", s_bresp_o, exp);
    end
    s_bready_i = 1'b1;
    @(posedge clk); #1;
    s_bready_i = 1'b0;
  endtask

  // Scoreboard push for a read / write, then the transaction itself.
  task automatic expect_read(input logic [31:0] addr);
    logic [AW-1:0] wa;
    wa = word_of(addr);
    if (in_range(addr)) begin
      exp_acc_q.push_back({1'b0, wa, 32'h0, 4'h0});
      exp_q.push_back({RESP_OKAY, ref_mem[wa]});
    end else begin
      exp_q.push_back({RESP_SLVERR, 32'h0});
    end
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
    logic [AW-1:0] wa;
    wa = word_of(addr);
    if (in_range(addr)) begin
      exp_acc_q.push_back({1'b1, wa, d, s});
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[wa][8*b +: 8] = d[8*b +: 8];
      exp_b_q.push_back(RESP_OKAY);
    end else begin
      exp_b_q.push_back(RESP_SLVERR);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold);
    expect_read(addr);
    @(negedge clk);
    send_ar(addr, 0);
    collect_r(hold);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                          input int w_dly, input int aw_dly, input int hold);
    expect_write(addr, d, s);
    @(negedge clk);
    fork
      send_aw(addr, aw_dly);
      send_w(d, s, w_dly);
    join
    collect_b(hold);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({s_arready_o, s_awready_o, s_wready_o, s_rvalid_o, s_bvalid_o, mem_req_o, mem_we_o,
         s_rdata_o, s_rresp_o, s_bresp_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b%b%b req=%b required all outputs 0",
               s_arready_o, s_awready_o, s_wready_o, mem_req_o);
    end
    @(negedge clk); rst_i = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({s_arready_o, s_awready_o, s_wready_o, s_rvalid_o, s_bvalid_o, mem_req_o} !== 6'b111000) begin
      errors++;
      $display("FAIL after_reset: got %b required 111000",
               {s_arready_o, s_awready_o, s_wready_o, s_rvalid_o, s_bvalid_o, mem_req_o});
    end
  endtask

  task automatic test_read();
    expect_read(32'h1000_0008);
    @(negedge clk);
    s_arvalid_i = 1'b1; s_araddr_i = 32'h1000_0008;
    #1;
    checks++;
    if (s_arready_o !== 1'b1) begin
      errors++; $display("FAIL read_arready: got %b required 1", s_arready_o);
    end
    @(posedge clk); #1;
    s_arvalid_i = 1'b0; s_araddr_i = '0;
    checks++;
    if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, 10'd2}) begin
      errors++;
      $display("FAIL read_req_t1: req=%b we=%b addr=%0d required 1 0 2", mem_req_o, mem_we_o, mem_addr_o);
    end
    @(posedge clk); #1;
    checks++;
    if (s_rvalid_o !== 1'b1) begin
      errors++; $display("FAIL read_rvalid_t2: got %b required 1", s_rvalid_o);
    end
    collect_r(0);
  endtask

  task automatic test_write_w_first();
    expect_write(32'h1000_0010, 32'hDEAD_BEEF, 4'b0101);
    @(negedge clk);
    fork
      send_w(32'hDEAD_BEEF, 4'b0101, 0);
      send_aw(32'h1000_0010, 3);
    join
    checks++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wstrb_o} !== {1'b1, 1'b1, 10'd4, 4'b0101}) begin
      errors++;
      $display("FAIL write_req_t1: req=%b we=%b addr=%0d strb=%b required 1 1 4 0101",
               mem_req_o, mem_we_o, mem_addr_o, mem_wstrb_o);
    end
    collect_b(0);
    do_read(32'h1000_0010, 0);
  endtask

  task automatic test_simultaneous();
    int n;
    n = 0;
    expect_read(32'h1000_0020);
    expect_write(32'h1000_0024, 32'h1234_5678, 4'b1111);
    @(negedge clk);
    s_arvalid_i = 1'b1; s_araddr_i = 32'h1000_0020;
    s_awvalid_i = 1'b1; s_awaddr_i = 32'h1000_0024;
    s_wvalid_i  = 1'b1; s_wdata_i  = 32'h1234_5678; s_wstrb_i = 4'b1111;
    #1;
    checks++;
    if ({s_arready_o, s_awready_o, s_wready_o} !== 3'b100) begin
      errors++;
      $display("FAIL simul_ready: got %b required 100", {s_arready_o, s_awready_o, s_wready_o});
    end
    @(posedge clk); #1;
    s_arvalid_i = 1'b0; s_araddr_i = '0;
    checks++;
    if ({s_awready_o, s_wready_o} !== 2'b00) begin
      errors++;
      $display("FAIL simul_wait: got %b required 00", {s_awready_o, s_wready_o});
    end
    collect_r(0);
    while (!(s_awready_o === 1'b1 && s_wready_o === 1'b1) && n < BUDGET) begin @(negedge clk); #1; n++; end
    checks++;
    if (n >= BUDGET) begin
      errors++;
      $display("FAIL simul_write_timeout: awready/wready=%b%b required 11", s_awready_o, s_wready_o);
    end else @(posedge clk);
    #1;
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
    collect_b(0);
  endtask

  task automatic test_stalls();
    int acc0;
    acc0 = acc_cnt;
    mem_stall = 5;
    do_read(32'h1000_0030, 3);
    checks++;
    if (acc_cnt - acc0 !== 1) begin
      errors++; $display("FAIL stall_access_count: got %0d required 1", acc_cnt - acc0);
    end
    mem_stall = 4;
    do_write(32'h1000_0034, 32'hCAFE_F00D, 4'b1010, 1, 0, 2);
    mem_stall = 0;
    do_read(32'h1000_0034, 0);
  endtask

  task automatic test_range();
    // Beyond the window and below BASE (wrap): SLVERR with the check enabled,
    // aliased OKAY accesses without it.
    do_read(BASE + 32'h1000, 0);
    do_read(BASE - 32'h4, 1);
    do_write(BASE + 32'h2004, 32'hA5A5_5A5A, 4'b1111, 0, 0, 0);
    do_read(32'h1000_0004, 0);
  endtask

  task automatic test_reset_midop();
    int b_seen;
    b_seen = 0;
    mem_stall = 30;
    exp_acc_q.push_back({1'b1, 10'd8, 32'h0BAD_0BAD, 4'b1111});
    @(negedge clk);
    fork
      send_aw(32'h1000_0020, 0);
      send_w(32'h0BAD_0BAD, 4'b1111, 0);
    join
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++; $display("FAIL midop_req: got %b required 1", mem_req_o);
    end
    @(negedge clk);
    #2 rst_i = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({s_arready_o, s_awready_o, s_wready_o, s_rvalid_o, s_bvalid_o, mem_req_o, mem_we_o,
         s_rdata_o, s_rresp_o, s_bresp_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} !== '0) begin
      errors++;
      $display("FAIL midop_reset_outputs: req=%b we=%b bvalid=%b required all outputs 0",
               mem_req_o, mem_we_o, s_bvalid_o);
    end
    mem_stall = 0;
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (s_bvalid_o !== 1'b0 || mem_req_o !== 1'b0) b_seen++;
    end
    checks++;
    if (b_seen != 0) begin
      errors++; $display("FAIL midop_dropped: bvalid/req seen %0d cycles required 0", b_seen);
    end
    do_read(32'h1000_0020, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d;
    for (int i = 0; i < 12; i++) begin
      a = BASE + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
      mem_stall = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        do_write(a, d, 4'($urandom_range(1, 15)), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2));
      end else begin
        do_read(a, $urandom_range(0, 2));
      end
    end
    mem_stall = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = 32'hC0DE_0000 | 32'(i);
      dut_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    test_reset();
    test_read();
    test_write_w_first();
    test_simultaneous();
    test_stalls();
    test_range();
    test_reset_midop();
    test_back_to_back();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() + exp_b_q.size() + exp_acc_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: r=%0d b=%0d acc=%0d left, required 0",
               exp_q.size(), exp_b_q.size(), exp_acc_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
